// File: rtl/punchout_pkg.sv
// Shared screen, sprite and request-record definitions
// for the punch-out sprite drawing path.
package punchout_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    localparam logic [1:0] SPR_ENEMY  = 2'd0;
    localparam logic [1:0] SPR_LEFT   = 2'd1;
    localparam logic [1:0] SPR_PLAYER = 2'd2;
    localparam logic [1:0] SPR_RIGHT  = 2'd3;

    typedef struct packed {
        logic [1:0] sprite;
        logic [7:0] x;
        logic [6:0] y;
        logic       erase;
    } draw_req_t;

    localparam int DRAW_REQ_W = $bits(draw_req_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_FLUSH
    } draw_state_e;

endpackage

// File: rtl/draw_req_fifo.sv
// Small synchronous request FIFO with simultaneous push/pop
// and a registered ready that is low during and just after reset.
module draw_req_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign ready   = ready_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers/occupancy; ready tracks the post-update count
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        ready_d  = (count_d != FULL_CNT);
    end

    // Pointer, count and ready state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array, written on an accepted push
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sprite_draw_engine.sv
// Queued sprite blitter: serializes each buffered request into
// one adapter pixel per clock with clipping and transparency.
module sprite_draw_engine
    import punchout_pkg::*;
#(
    parameter int         SPRITE_W      = 40,
    parameter int         SPRITE_H      = 40,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter bit         TRANSP_EN     = 1'b1,
    parameter logic [2:0] TRANSP_COLOUR = 3'b101
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sprite,
    input  logic [7:0]  req_x,
    input  logic [6:0]  req_y,
    input  logic        req_erase,
    output logic [12:0] rom_addr,
    input  logic [2:0]  rom_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

    draw_state_e state_q, state_d;
    draw_req_t   cur_q, cur_d;
    draw_req_t   fifo_din, fifo_dout;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [10:0] pix_q, pix_d;
    logic [12:0] rom_addr_q;
    logic        s1_valid_q, s1_valid_d;
    logic        s1_erase_q, s1_erase_d;
    logic [8:0]  s1_x_q, s1_x_d;
    logic [7:0]  s1_y_q, s1_y_d;
    logic        fifo_full, fifo_empty, fifo_ready;
    logic        accept, pop;
    logic        clipped, transp;

    assign fifo_din = '{sprite: req_sprite, x: req_x,
                        y: req_y, erase: req_erase};
    assign req_ready = fifo_ready;
    assign accept    = req_valid && fifo_ready && !fifo_full;

    draw_req_fifo #(
        .WIDTH(DRAW_REQ_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (accept),
        .pop  (pop),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .ready(fifo_ready)
    );

    // Sequencer: pop/latch a request, raster its pixels, retire ROM read
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop     = 1'b1;
                cur_d   = fifo_dout;
                col_d   = '0;
                row_d   = '0;
                pix_d   = '0;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                pix_d = pix_q + 11'd1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                    if (row_q == ROW_LAST) state_d = ST_FLUSH;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            ST_FLUSH: begin
                state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1 travels alongside the one-cycle ROM latency
    always_comb begin
        s1_valid_d = (state_q == ST_DRAW);
        s1_erase_d = cur_q.erase;
        s1_x_d     = {1'b0, cur_q.x} + 9'(col_q);
        s1_y_d     = {1'b0, cur_q.y} + 8'(row_q);
    end

    // Address is live only while drawing, otherwise the last one holds
    assign rom_addr = (state_q == ST_DRAW) ? {cur_q.sprite, pix_q}
                                           : rom_addr_q;

    // FSM, counters, held address and stage-1 registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_q      <= '0;
            rom_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_erase_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pix_q      <= pix_d;
            rom_addr_q <= rom_addr;
            s1_valid_q <= s1_valid_d;
            s1_erase_q <= s1_erase_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
        end
    end

    // Stage 2: off-screen slots are consumed without a write strobe
    assign clipped = (s1_x_q > 9'(SCREEN_W - 1)) ||
                     (s1_y_q > 8'(SCREEN_H - 1));
    assign transp  = TRANSP_EN && !s1_erase_q &&
                     (rom_q == TRANSP_COLOUR);
    assign plot    = s1_valid_q && !clipped && !transp;
    assign colour  = !s1_valid_q ? 3'b000 :
                     (s1_erase_q ? BG_COLOUR : rom_q);
    assign x       = s1_x_q[7:0];
    assign y       = s1_y_q[6:0];
    assign done    = (state_q == ST_FLUSH);
    assign busy    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Self-checking bench for sprite_draw_engine: directed vectors,
// back-pressure, reset abort and random requests against a pixel model.
module tb_sprite_draw_engine;
    import punchout_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_sprite = '0;
    logic [7:0]  req_x = '0;
    logic [6:0]  req_y = '0;
    logic        req_erase = 1'b0;
    logic [12:0] rom_addr;
    logic [2:0]  rom_q = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    sprite_draw_engine dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sprite(req_sprite),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_erase (req_erase),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input bit ok, input string nm,
                         input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ROM contents by mode: 0 = addr[2:0], 1 = key on even addr,
    // 2 = scrambled pattern
    int rom_mode = 0;

    function automatic logic [2:0] rom_f(input logic [12:0] a, input int m);
        int v;
        v = int'(a);
        if (m == 0) return a[2:0];
        if (m == 1) return a[0] ? 3'b011 : 3'b101;
        return 3'(v * 7 + (v >> 5) + (v >> 9));
    endfunction

    logic [12:0] addr_s = '0;
    always @(negedge clock) addr_s <= rom_addr;
    always @(posedge clock) rom_q <= rom_f(addr_s, rom_mode);

    function automatic int pk(input int px, input int py, input int c);
        return (px << 10) | (py << 3) | c;
    endfunction

    // Expected plotted pixels, in the order they must appear
    int exp_q[$];

    task automatic model_push(input logic [1:0] s, input int x0,
                              input int y0, input bit er, output int n);
        logic [12:0] a;
        logic [2:0]  c;
        int px, py;
        n = 0;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 40; k++) begin
                a  = {s, 11'(r * 40 + k)};
                c  = rom_f(a, rom_mode);
                px = x0 + k;
                py = y0 + r;
                if (px < SCREEN_W && py < SCREEN_H &&
                    (er || c != 3'b101)) begin
                    exp_q.push_back(pk(px, py, er ? 0 : int'(c)));
                    n++;
                end
            end
        end
    endtask

    int plots_seen = 0;
    int dones = 0;
    int first_plot_cyc = -1;
    int done_cyc[$];

    always @(negedge clock) begin
        int act, e;
        if (plot) begin
            act = pk(int'(x), int'(y), int'(colour));
            plots_seen++;
            if (first_plot_cyc < 0) first_plot_cyc = cyc;
            if (exp_q.size() == 0) begin
                check(exp_q.size() != 0, "extra_plot", act, -1);
            end else begin
                e = exp_q.pop_front();
                check(act == e, "pixel", act, e);
            end
        end
        if (done) begin
            dones++;
            done_cyc.push_back(cyc);
        end
    end

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input int px, input int py,
                        input bit er, output int acc, output int n);
        int w;
        w = 0;
        acc = -1;
        n = 0;
        tick;
        req_valid  = 1'b1;
        req_sprite = s;
        req_x      = 8'(px);
        req_y      = 7'(py);
        req_erase  = er;
        while (!req_ready && w < 5000) begin
            tick;
            w++;
        end
        check(req_ready == 1'b1, "accept_wait", w, 0);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        model_push(s, px, py, er, n);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int w;
        w = 0;
        while (dones < target && w < budget) begin
            tick;
            w++;
        end
        check(dones >= target, "done_wait", dones, target);
    endtask

    typedef struct {
        logic [1:0] s;
        int         x;
        int         y;
        bit         er;
        int         mode;
        int         exp_n;
        bit         lat;
    } vec_t;

    vec_t tv[8];

    initial begin
        int acc, n, d0, ps, w, tot;
        int accs[6];

        tv[0] = '{2'd2,  40,  70, 1'b0, 0, 1400, 1'b1};
        tv[1] = '{2'd0, 150, 100, 1'b0, 0,  180, 1'b1};
        tv[2] = '{2'd1,   0,   0, 1'b0, 1,  800, 1'b0};
        tv[3] = '{2'd1,   0,   0, 1'b1, 1, 1600, 1'b1};
        tv[4] = '{2'd3, 159, 119, 1'b0, 0,    1, 1'b1};
        tv[5] = '{2'd0, 121,  81, 1'b0, 0, 1326, 1'b1};
        tv[6] = '{2'd2, 200,  10, 1'b0, 0,    0, 1'b0};
        tv[7] = '{2'd3,   0, 119, 1'b0, 0,   35, 1'b1};

        // Reset state
        repeat (3) tick;
        check(plot == 1'b0, "rst_plot", plot, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(done == 1'b0, "rst_done", done, 0);
        check(req_ready == 1'b0, "rst_ready", req_ready, 0);
        check(colour == 3'b000, "rst_colour", colour, 0);
        check(x == 8'd0 && y == 7'd0, "rst_xy", {x, y}, 0);
        check(rom_addr == 13'd0, "rst_addr", rom_addr, 0);
        reset = 1'b0;
        tick;
        check(req_ready == 1'b1, "ready_after_rst", req_ready, 1);

        // Directed vectors, one request at a time from idle
        for (int i = 0; i < 8; i++) begin
            rom_mode = tv[i].mode;
            plots_seen = 0;
            first_plot_cyc = -1;
            d0 = dones;
            send(tv[i].s, tv[i].x, tv[i].y, tv[i].er, acc, n);
            wait_dones(d0 + 1, 2000);
            if (dones > d0)
                check(done_cyc[d0] - acc == 1602, "done_latency",
                      done_cyc[d0] - acc, 1602);
            if (tv[i].lat)
                check(first_plot_cyc - acc == 3, "first_plot_latency",
                      first_plot_cyc - acc, 3);
            check(plots_seen == tv[i].exp_n, "plot_count",
                  plots_seen, tv[i].exp_n);
            check(exp_q.size() == 0, "pixels_left", exp_q.size(), 0);
            tick;
            check(busy == 1'b0 && done == 1'b0, "idle_after_done",
                  {busy, done}, 0);
        end

        // Back-pressure: six requests pushed back to back
        rom_mode = 2;
        d0 = dones;
        for (int i = 0; i < 6; i++) begin
            send(2'($urandom_range(0, 3)), $urandom_range(0, 200),
                 $urandom_range(0, 127), $urandom_range(0, 3) == 0,
                 accs[i], n);
            if (i == 3) check(req_ready == 1'b1, "ready_at_3", req_ready, 1);
            if (i == 4) check(req_ready == 1'b0, "ready_full", req_ready, 0);
        end
        check(accs[4] - accs[0] == 4, "b2b_accepts", accs[4] - accs[0], 4);
        check(accs[5] - accs[0] == 1605, "ready_reassert",
              accs[5] - accs[0], 1605);
        wait_dones(d0 + 6, 6 * 1602 + 200);
        if (dones >= d0 + 6) begin
            check(done_cyc[d0] - accs[0] == 1602, "bp_first_done",
                  done_cyc[d0] - accs[0], 1602);
            for (int k = 1; k < 6; k++)
                check(done_cyc[d0 + k] - done_cyc[d0 + k - 1] == 1602,
                      "done_spacing",
                      done_cyc[d0 + k] - done_cyc[d0 + k - 1], 1602);
        end
        check(exp_q.size() == 0, "bp_pixels_left", exp_q.size(), 0);

        // Random requests with random gaps
        d0 = dones;
        plots_seen = 0;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) tick;
            send(2'($urandom_range(0, 3)), $urandom_range(0, 255),
                 $urandom_range(0, 127), $urandom_range(0, 3) == 0,
                 acc, n);
            tot += n;
        end
        wait_dones(d0 + 4, 4 * 1602 + 200);
        tick;
        check(plots_seen == tot, "rand_plot_count", plots_seen, tot);
        check(exp_q.size() == 0, "rand_pixels_left", exp_q.size(), 0);

        // Reset at pixel 500 with two requests queued
        rom_mode = 0;
        d0 = dones;
        send(2'd2, 10, 10, 1'b0, accs[0], n);
        send(2'd1, 20, 20, 1'b0, accs[1], n);
        send(2'd3, 30, 30, 1'b0, accs[2], n);
        w = 0;
        while (cyc < accs[0] + 503 && w < 3000) begin
            tick;
            w++;
        end
        check(busy == 1'b1, "busy_mid_draw", busy, 1);
        reset = 1'b1;
        #1;
        check(plot == 1'b0, "abort_plot", plot, 0);
        check(busy == 1'b0, "abort_busy", busy, 0);
        check(done == 1'b0, "abort_done", done, 0);
        exp_q.delete();
        repeat (3) tick;
        reset = 1'b0;
        ps = plots_seen;
        repeat (3400) tick;
        check(plots_seen == ps, "post_reset_plots", plots_seen - ps, 0);
        check(dones == d0, "post_reset_dones", dones - d0, 0);
        check(busy == 1'b0, "post_reset_busy", busy, 0);

        // New request after abort draws normally
        plots_seen = 0;
        d0 = dones;
        send(2'd0, 5, 5, 1'b0, acc, n);
        wait_dones(d0 + 1, 2000);
        check(plots_seen == 1400, "recover_plots", plots_seen, 1400);
        check(exp_q.size() == 0, "recover_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
